ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
// - EX->MEM pipeline register of the 64-bit RISC-V style pipeline.
// - Sits between the execute stage (ALU) and the memory-access stage.
// - Latches the ALU result, the store data, the destination register and the
//   MEM/WB control bits.
// - Supports hold (stall) and bubble insertion (flush).
// PARAMETERS
// - DATA_W  64  width of ALU result and store-data paths
// - REG_W   5   width of destination register index
// PORTS
// - clk           in   1       rising-edge clock; one clock domain
// - reset         in   1       asynchronous, active-low reset (0 = reset asserted)
// - stall         in   1       1 = hold current contents
// - flush         in   1       1 = load a bubble (all outputs zero)
// - RegWrite      in   1       EX control: write register file in WB
// - MemtoReg      in   1       EX control: WB selects memory data
// - MemWrite      in   1       EX control: store to data memory
// - AluResult     in   DATA_W  ALU result / memory address
// - Datain        in   DATA_W  store data (rs2 value)
// - Rd_in         in   REG_W   destination register index
// - RegWrite_Out  out  1       registered RegWrite
// - MemtoReg_Out  out  1       registered MemtoReg
// - MemWrite_Out  out  1       registered MemWrite
// - AluOut        out  DATA_W  registered AluResult
// - DataOut       out  DATA_W  registered Datain
// - Rd_out        out  REG_W   registered Rd_in
// BEHAVIOUR
// - Reset:
//   - reset==0 clears every output to 0 immediately, independent of clk.
//   - Outputs stay 0 while reset is held low.
//   - The first capture happens on the first rising clk edge after reset goes to 1.
// - Each rising clk edge while reset==1, in priority order:
//   1. flush==1: all outputs load 0. Flush has priority over stall.
//   2. stall==1: all outputs keep their current values.
//   3. Otherwise: every *_Out / AluOut / DataOut / Rd_out loads its matching input.
// - Latency: exactly 1 cycle, input to output.
// - No combinational path from any input to any output.
// - Values pass through unmodified:
//   - no arithmetic, no sign handling, no gating of Rd_out by RegWrite;
//   - Rd_in==0 is passed through as 0.
// - All outputs change only on the clk edge or on reset assertion. No glitches
//   between edges.
// - reset asserted mid-operation (including during stall or flush) wins
//   immediately. All state is lost.
// CONFIGURATION
// - EX_MEM_PC_TRACE_EN defined:
//   - adds input pc_in [63:0] and output pc_out [63:0];
//   - pc_out follows the same reset, flush, stall and capture rules as AluOut.
// - EX_MEM_PC_TRACE_EN undefined:
//   - the ports and the register are absent;
//   - all other behaviour is identical.
// TESTING
// - reset=0 with arbitrary inputs -> all outputs 0 at once, with no clk edge needed.
// - reset 0->1, all inputs 0, one clk -> all outputs 0.
// - Capture: RegWrite=1, MemtoReg=0, MemWrite=1, AluResult=64'h0123_4567_89AB_CDEF,
//   Datain=64'hDEAD_BEEF_0000_0001, Rd_in=5'd17, clk edge
//   -> outputs equal those values after that edge, not before it.
// - Stall: after the capture above, stall=1 with new inputs for 3 clks
//   -> outputs unchanged; stall=0 -> new values appear after the next edge.
// - Flush: stall=1 and flush=1 together -> all outputs 0 after the edge.
// - Async reset mid-cycle with outputs non-zero -> outputs 0 before the next edge.
//   Same check with EX_MEM_PC_TRACE_EN defined: pc_in=64'h1000 -> pc_out=64'h1000
//   one cycle later.

Source files
------------

// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM boundary bundle: stage controls, execute-side inputs and memory-side outputs.
// Latency: none (wires only).
// Backpressure: stall holds the register contents; flush loads a bubble.
//
// Signals:
//   stall, flush                      stage controls
//   RegWrite, MemtoReg, MemWrite      execute-side control bits
//   AluResult, Datain, Rd_in          execute-side data
//   *_Out, AluOut, DataOut, Rd_out    registered copies presented to MEM
//   pc_in / pc_out                    present only with EX_MEM_PC_TRACE_EN
// Modports: master drives the execute side; slave is the pipeline register.
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
);
    logic              stall;
    logic              flush;
    logic              RegWrite;
    logic              MemtoReg;
    logic              MemWrite;
    logic [DATA_W-1:0] AluResult;
    logic [DATA_W-1:0] Datain;
    logic [REG_W-1:0]  Rd_in;
    logic              RegWrite_Out;
    logic              MemtoReg_Out;
    logic              MemWrite_Out;
    logic [DATA_W-1:0] AluOut;
    logic [DATA_W-1:0] DataOut;
    logic [REG_W-1:0]  Rd_out;
`ifdef EX_MEM_PC_TRACE_EN
    logic [63:0]       pc_in;
    logic [63:0]       pc_out;
`endif

    modport master (
`ifdef EX_MEM_PC_TRACE_EN
        output pc_in,
        input  pc_out,
`endif
        output stall, flush, RegWrite, MemtoReg, MemWrite, AluResult, Datain, Rd_in,
        input  RegWrite_Out, MemtoReg_Out, MemWrite_Out, AluOut, DataOut, Rd_out
    );

    modport slave (
`ifdef EX_MEM_PC_TRACE_EN
        input  pc_in,
        output pc_out,
`endif
        input  stall, flush, RegWrite, MemtoReg, MemWrite, AluResult, Datain, Rd_in,
        output RegWrite_Out, MemtoReg_Out, MemWrite_Out, AluOut, DataOut, Rd_out
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register: latches ALU result, store data, rd and MEM/WB control.
// Latency: exactly 1 clk from input to output; no combinational input->output path.
// Backpressure: stall holds contents; flush (higher priority) loads an all-zero bubble.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; clears every output immediately
//   bus    ex_mem_pipe_reg_if.slave (stall/flush, execute inputs, registered outputs)
// Optional feature: define EX_MEM_PC_TRACE_EN to carry pc_in -> pc_out through
// the same register with identical reset/flush/stall/capture rules.
module ex_mem_pipe_reg #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    ex_mem_pipe_reg_if.slave    bus
);

    // One packed word for the whole stage so reset, flush and hold act on
    // every field together and no field can be forgotten.
    typedef struct packed {
`ifdef EX_MEM_PC_TRACE_EN
        logic [63:0]       pc;
`endif
        logic              regWrite;
        logic              memtoReg;
        logic              memWrite;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] storeData;
        logic [REG_W-1:0]  rd;
    } exMemStage_t;

    exMemStage_t stageIn;
    exMemStage_t stageQ;

    // Values pass through untouched: no sign handling, rd is not gated by RegWrite.
    always_comb begin
        stageIn           = '0;
`ifdef EX_MEM_PC_TRACE_EN
        stageIn.pc        = bus.pc_in;
`endif
        stageIn.regWrite  = bus.RegWrite;
        stageIn.memtoReg  = bus.MemtoReg;
        stageIn.memWrite  = bus.MemWrite;
        stageIn.aluResult = bus.AluResult;
        stageIn.storeData = bus.Datain;
        stageIn.rd        = bus.Rd_in;
    end

    // Flush is checked before stall so a squashed instruction never survives a hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stageQ <= '0;
        end else if (bus.flush) begin
            stageQ <= '0;
        end else if (!bus.stall) begin
            stageQ <= stageIn;
        end
    end

    // Outputs come straight from flops, so they move only on clk or reset.
`ifdef EX_MEM_PC_TRACE_EN
    assign bus.pc_out       = stageQ.pc;
`endif
    assign bus.RegWrite_Out = stageQ.regWrite;
    assign bus.MemtoReg_Out = stageQ.memtoReg;
    assign bus.MemWrite_Out = stageQ.memWrite;
    assign bus.AluOut       = stageQ.aluResult;
    assign bus.DataOut      = stageQ.storeData;
    assign bus.Rd_out       = stageQ.rd;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: a transaction-level model predicts the
// outputs after every edge and a compare process checks them each cycle,
// alongside hand-computed literal expectations at key points.
module tb_ex_mem_pipe_reg;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clkEn = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    ex_mem_pipe_reg_if #(.DATA_W(64), .REG_W(5)) bus ();

    ex_mem_pipe_reg #(.DATA_W(64), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always begin
        #5;
        if (clkEn) clk = ~clk;
    end

    // Expected contents of the stage as seen by MEM.
    typedef struct {
        logic        regWrite;
        logic        memtoReg;
        logic        memWrite;
        logic [63:0] alu;
        logic [63:0] dat;
        logic [4:0]  rd;
        logic [63:0] pc;
    } stageView_t;

    stageView_t expView;
    logic       checkEn = 1'b0;

    function automatic stageView_t zeroView();
        stageView_t v;
        v.regWrite = 1'b0; v.memtoReg = 1'b0; v.memWrite = 1'b0;
        v.alu = 64'd0; v.dat = 64'd0; v.rd = 5'd0; v.pc = 64'd0;
        return v;
    endfunction

    function automatic logic [135:0] dutVec();
        return {bus.RegWrite_Out, bus.MemtoReg_Out, bus.MemWrite_Out,
                bus.AluOut, bus.DataOut, bus.Rd_out};
    endfunction

    function automatic logic [135:0] viewVec(stageView_t v);
        return {v.regWrite, v.memtoReg, v.memWrite, v.alu, v.dat, v.rd};
    endfunction

    task automatic compareView(string name, stageView_t v);
        nChecks++;
        if (dutVec() !== viewVec(v)) begin
            nFails++;
            $display("FAIL %s: got %h required %h at %0t", name, dutVec(), viewVec(v), $time);
        end
`ifdef EX_MEM_PC_TRACE_EN
        nChecks++;
        if (bus.pc_out !== v.pc) begin
            nFails++;
            $display("FAIL %s.pc: got %h required %h at %0t", name, bus.pc_out, v.pc, $time);
        end
`endif
    endtask

    task automatic checkLit(string name, logic rw, logic mr, logic mw,
                            logic [63:0] alu, logic [63:0] dat, logic [4:0] rd);
        stageView_t v;
        v = zeroView();
        v.regWrite = rw; v.memtoReg = mr; v.memWrite = mw;
        v.alu = alu; v.dat = dat; v.rd = rd; v.pc = expView.pc;
        compareView(name, v);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) compareView("model", expView);
    end

    task automatic drive(logic rw, logic mr, logic mw, logic [63:0] alu,
                         logic [63:0] dat, logic [4:0] rd, logic [63:0] pc);
        bus.RegWrite = rw; bus.MemtoReg = mr; bus.MemWrite = mw;
        bus.AluResult = alu; bus.Datain = dat; bus.Rd_in = rd;
`ifdef EX_MEM_PC_TRACE_EN
        bus.pc_in = pc;
`else
        if (pc != 64'd0) begin end
`endif
    endtask

    // One clock with the current inputs; the model applies the stage rules:
    // reset low -> empty, flush -> bubble, stall -> unchanged, else capture.
    task automatic cycle();
        @(posedge clk);
        if (!reset) begin
            expView = zeroView();
        end else if (bus.flush) begin
            expView = zeroView();
        end else if (!bus.stall) begin
            expView.regWrite = bus.RegWrite;
            expView.memtoReg = bus.MemtoReg;
            expView.memWrite = bus.MemWrite;
            expView.alu      = bus.AluResult;
            expView.dat      = bus.Datain;
            expView.rd       = bus.Rd_in;
`ifdef EX_MEM_PC_TRACE_EN
            expView.pc       = bus.pc_in;
`endif
        end
        #2;
    endtask

    initial begin
        expView   = zeroView();
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A, 5'd31, 64'h77);

        // Reset with arbitrary inputs and no clock at all.
        #3 reset = 1'b0;
        #1 checkLit("reset_no_clk", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        clkEn   = 1'b1;
        checkEn = 1'b1;
        cycle();
        cycle();
        checkLit("reset_held", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);

        // Release reset with all inputs zero.
        reset = 1'b1; bus.flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 64'd0);
        cycle();
        checkLit("first_zero_capture", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);

        // Capture: visible only after the edge.
        drive(1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 5'd17, 64'h1000);
        #1 checkLit("capture_before_edge", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        cycle();
        checkLit("capture", 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 5'd17);
`ifdef EX_MEM_PC_TRACE_EN
        nChecks++;
        if (bus.pc_out !== 64'h1000) begin
            nFails++;
            $display("FAIL pc_capture: got %h required %h", bus.pc_out, 64'h1000);
        end
`endif

        // Stall three cycles with different inputs.
        bus.stall = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0042, 5'd3, 64'h2000);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkLit("stall_hold", 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 5'd17);
        end
        bus.stall = 1'b0;
        #1 checkLit("stall_release_pre", 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001, 5'd17);
        cycle();
        checkLit("stall_release", 1'b0, 1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_0042, 5'd3);

        // Flush together with stall: bubble wins.
        bus.stall = 1'b1; bus.flush = 1'b1;
        cycle();
        checkLit("flush_over_stall", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        bus.stall = 1'b0; bus.flush = 1'b0;

        // rd passes through even with RegWrite low; rd==0 passes as 0.
        drive(1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'h3000);
        cycle();
        checkLit("rd_not_gated", 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
        drive(1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 64'h1234_5678_9ABC_DEF0, 5'd0, 64'h3004);
        cycle();
        checkLit("rd_zero", 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 64'h1234_5678_9ABC_DEF0, 5'd0);

        // Flush alone clears a live stage.
        bus.flush = 1'b1;
        cycle();
        checkLit("flush_alone", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        bus.flush = 1'b0;

        // Refill, then assert reset mid-cycle during a stall.
        drive(1'b1, 1'b1, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 64'h0BAD_0BAD_0BAD_0BAD, 5'd30, 64'h4000);
        cycle();
        checkLit("refill", 1'b1, 1'b1, 1'b1, 64'hCAFE_F00D_CAFE_F00D, 64'h0BAD_0BAD_0BAD_0BAD, 5'd30);
        bus.stall = 1'b1;
        #1 reset = 1'b0;
        expView = zeroView();
        #1 checkLit("async_reset_mid", 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 5'd0);
        cycle();
        bus.stall = 1'b0;
        reset = 1'b1;

        // A short directed burst after recovery.
        drive(1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000, 5'd1, 64'h1000);
        cycle();
        checkLit("post_reset_capture", 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000, 5'd1);
        drive(1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 5'd16, 64'h1004);
        cycle();
        drive(1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000, 5'd15, 64'h1008);
        cycle();
        checkLit("burst_last", 1'b1, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_0000_0000, 5'd15);

        checkEn = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
